axi_rd_arb: RTL and testbench

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb.sv | 166 ++++++++++++++++
 tb/tb_axi_rd_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// -----------------------------------------------------------------------------
// axi_rd_arb
// Round-robin arbiter that drains NUM_REQ show-ahead address FIFOs onto one AXI
// read-address channel. Each issued beat is copied into a transaction-tracking
// FIFO. An outstanding counter limits how many transactions can be in flight.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   req_fifo_empty    : per-requester empty flags
//   req_fifo_rddata   : packed FIFO heads, 97 bits per requester
//   req_fifo_rd       : one-hot pop pulse, issued in the grant cycle
//   axi_ax*           : AXI address channel (valid/ready, id, addr, len, size)
//   rsp_done          : one-cycle pulse, one outstanding transaction completed
//   transfifo_wr/data : tracking FIFO write, pulses on the address handshake
//   grant_id          : requester that owns the current beat
//   outstanding_cnt   : issued-but-uncompleted transaction count
//   err_underflow     : sticky, set by rsp_done while nothing is outstanding
// -----------------------------------------------------------------------------
module axi_rd_arb #(
   parameter  int NUM_REQ         = 4,
   parameter  int MAX_OUTSTANDING = 8,
   localparam int GW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_fifo_empty,
   input  logic [NUM_REQ*97-1:0]  req_fifo_rddata,
   output logic [NUM_REQ-1:0]     req_fifo_rd,
   input  logic                   axi_axready,
   output logic                   axi_axvalid,
   output logic [5:0]             axi_aid,
   output logic [63:0]            axi_addr,
   output logic [7:0]             axi_alen,
   output logic [2:0]             axi_asize,
   input  logic                   rsp_done,
   output logic                   transfifo_wr,
   output logic [96:0]            transfifo_wrdata,
   output logic [GW-1:0]          grant_id,
   output logic [7:0]             outstanding_cnt,
   output logic                   err_underflow
);

   typedef struct packed {
      logic [15:0] tag;
      logic [2:0]  asize;
      logic [7:0]  alen;
      logic [5:0]  aid;
      logic [63:0] addr;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

   localparam logic [7:0] MAX_C = 8'(MAX_OUTSTANDING);

   entry_t [NUM_REQ-1:0] heads;
   assign heads = req_fifo_rddata;

   state_t          state_q, state_d;
   entry_t          entry_q, entry_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            err_q, err_d;

   logic            pending, room, grant_en, hs;
   logic            hi_found;
   logic [GW-1:0]   lo_idx, hi_idx, win_idx;

   assign pending = |(~req_fifo_empty);
   assign room    = (cnt_q < MAX_C);

   // Round-robin search from last_grant+1: the lowest non-empty index above the
   // last grant wins; if none exists the search wraps to the lowest overall.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      hi_found = 1'b0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (!req_fifo_empty[i]) begin
            lo_idx = GW'(i);
            if (GW'(i) > last_grant_q) begin
               hi_idx   = GW'(i);
               hi_found = 1'b1;
            end
         end
      end
      win_idx = hi_found ? hi_idx : lo_idx;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pending && room) state_d = ISSUE;
                  else if (pending)    state_d = STALL;
         ISSUE:   if (axi_axready)     state_d = IDLE;
         STALL:   if (room)            state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // The pop is combinational so the FIFO head is consumed in the same cycle it
   // is captured; reset gates it because state_q reads IDLE during reset.
   always_comb begin
      grant_en     = (state_q == IDLE) && pending && room && !reset;
      hs           = (state_q == ISSUE) && axi_axready;
      axi_axvalid  = (state_q == ISSUE);
      transfifo_wr = hs;
      for (int i = 0; i < NUM_REQ; i++)
         req_fifo_rd[i] = grant_en && (win_idx == GW'(i));
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      entry_d      = entry_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      if (grant_en) begin
         entry_d = heads[win_idx];
         grant_d = win_idx;
      end
      if (hs) last_grant_d = grant_q;
      // Handshake and completion in the same cycle cancel out.
      case ({hs, rsp_done})
         2'b10:   cnt_d = cnt_q + 8'd1;
         2'b01:   if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                  else               err_d = 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_q      <= '0;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_REQ-1);
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         entry_q      <= entry_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign axi_addr         = entry_q.addr;
   assign axi_aid          = entry_q.aid;
   assign axi_alen         = entry_q.alen;
   assign axi_asize        = entry_q.asize;
   assign transfifo_wrdata = entry_q;
   assign grant_id         = grant_q;
   assign outstanding_cnt  = cnt_q;
   assign err_underflow    = err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: four requester FIFOs modelled as small arrays,
// outstanding limit set to 2 so the stall path is reachable quickly.
module tb_axi_rd_arb;
   localparam int NR = 4;
   localparam int MO = 2;

   logic             clk;
   logic             reset;
   logic [NR-1:0]    req_fifo_empty;
   logic [NR*97-1:0] req_fifo_rddata;
   logic [NR-1:0]    req_fifo_rd;
   logic             axi_axready;
   logic             axi_axvalid;
   logic [5:0]       axi_aid;
   logic [63:0]      axi_addr;
   logic [7:0]       axi_alen;
   logic [2:0]       axi_asize;
   logic             rsp_done;
   logic             transfifo_wr;
   logic [96:0]      transfifo_wrdata;
   logic [1:0]       grant_id;
   logic [7:0]       outstanding_cnt;
   logic             err_underflow;

   int checks = 0;
   int errors = 0;

   logic [96:0] mem [NR][8];
   int rp [NR];
   int wp [NR];

   axi_rd_arb #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .reset(reset),
      .req_fifo_empty(req_fifo_empty), .req_fifo_rddata(req_fifo_rddata),
      .req_fifo_rd(req_fifo_rd), .axi_axready(axi_axready),
      .axi_axvalid(axi_axvalid), .axi_aid(axi_aid), .axi_addr(axi_addr),
      .axi_alen(axi_alen), .axi_asize(axi_asize), .rsp_done(rsp_done),
      .transfifo_wr(transfifo_wr), .transfifo_wrdata(transfifo_wrdata),
      .grant_id(grant_id), .outstanding_cnt(outstanding_cnt),
      .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [96:0] mk(input logic [63:0] a, input logic [5:0] id,
                                      input logic [7:0] len, input logic [2:0] sz,
                                      input logic [15:0] tag);
      return {tag, sz, len, id, a};
   endfunction

   task automatic refresh();
      for (int i = 0; i < NR; i++) begin
         req_fifo_empty[i] = (rp[i] == wp[i]);
         req_fifo_rddata[97*i +: 97] = (rp[i] == wp[i]) ? 97'd0 : mem[i][rp[i]];
      end
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < NR; i++) begin
         rp[i] = 0;
         wp[i] = 0;
      end
   endtask

   task automatic push(input int i, input logic [96:0] e);
      mem[i][wp[i]] = e;
      wp[i]++;
   endtask

   // One clock: sample the pop request before the edge, apply it after.
   task automatic tick();
      logic [NR-1:0] pend;
      #1;
      pend = req_fifo_rd;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
         if (pend[i] && rp[i] != wp[i]) rp[i]++;
      refresh();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      axi_axready = 1'b0;
      rsp_done = 1'b0;
      clear_fifos();
      refresh();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; axi_axready = 1'b0; rsp_done = 1'b0;
      clear_fifos();
      push(1, mk(64'hDEAD, 6'd1, 8'd1, 3'd1, 16'h1));
      refresh();
      #2;
      checks++; if (axi_axvalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", axi_axvalid); end
      checks++; if (req_fifo_rd !== 4'b0) begin errors++; $display("FAIL rst_rd got %b exp 0000", req_fifo_rd); end
      checks++; if (transfifo_wr !== 1'b0) begin errors++; $display("FAIL rst_twr got %0b exp 0", transfifo_wr); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err_underflow); end
      checks++; if (outstanding_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", outstanding_cnt); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid got %0d exp 0", grant_id); end
      checks++; if ({axi_asize, axi_alen, axi_aid, axi_addr} !== 81'd0) begin errors++; $display("FAIL rst_fields got %h exp 0", {axi_asize, axi_alen, axi_aid, axi_addr}); end
      tick();
      checks++; if (axi_axvalid !== 1'b0 || req_fifo_rd !== 4'b0) begin errors++; $display("FAIL rst_hold got valid %0b rd %b exp 0 0000", axi_axvalid, req_fifo_rd); end
      clear_fifos();
      refresh();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_single();
      logic [96:0] e;
      e = mk(64'h1000, 6'd5, 8'd3, 3'd2, 16'hBEEF);
      push(2, e);
      axi_axready = 1'b1;
      refresh();
      #1;
      checks++; if (req_fifo_rd !== 4'b0100) begin errors++; $display("FAIL single_pop got %b exp 0100", req_fifo_rd); end
      checks++; if (axi_axvalid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %0b exp 0", axi_axvalid); end
      tick();
      checks++; if (axi_axvalid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", axi_axvalid); end
      checks++; if (axi_addr !== 64'h1000) begin errors++; $display("FAIL single_addr got %h exp 1000", axi_addr); end
      checks++; if (axi_aid !== 6'd5 || axi_alen !== 8'd3 || axi_asize !== 3'd2) begin errors++; $display("FAIL single_fields got aid %0d len %0d size %0d exp 5 3 2", axi_aid, axi_alen, axi_asize); end
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got %0d exp 2", grant_id); end
      checks++; if (transfifo_wr !== 1'b1) begin errors++; $display("FAIL single_twr got %0b exp 1", transfifo_wr); end
      checks++; if (transfifo_wrdata !== e) begin errors++; $display("FAIL single_twdata got %h exp %h", transfifo_wrdata, e); end
      checks++; if (req_fifo_rd !== 4'b0) begin errors++; $display("FAIL single_nopop got %b exp 0000", req_fifo_rd); end
      tick();
      checks++; if (outstanding_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", outstanding_cnt); end
      checks++; if (axi_axvalid !== 1'b0 || transfifo_wr !== 1'b0) begin errors++; $display("FAIL single_after got valid %0b twr %0b exp 0 0", axi_axvalid, transfifo_wr); end
   endtask

   task automatic test_backpressure();
      logic [96:0] e0, e1;
      do_reset();
      e0 = mk(64'hCAFE_0000, 6'd9, 8'd7, 3'd3, 16'h1234);
      e1 = mk(64'hCAFE_0040, 6'd10, 8'd1, 3'd4, 16'h5678);
      push(1, e0);
      push(1, e1);
      refresh();
      #1;
      checks++; if (req_fifo_rd !== 4'b0010) begin errors++; $display("FAIL bp_pop got %b exp 0010", req_fifo_rd); end
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++; if (axi_axvalid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %0b exp 1", k, axi_axvalid); end
         checks++; if ({axi_asize, axi_alen, axi_aid, axi_addr} !== e0[80:0]) begin errors++; $display("FAIL bp_stable cyc %0d got %h exp %h", k, {axi_asize, axi_alen, axi_aid, axi_addr}, e0[80:0]); end
         checks++; if (transfifo_wr !== 1'b0) begin errors++; $display("FAIL bp_twr cyc %0d got %0b exp 0", k, transfifo_wr); end
         checks++; if (req_fifo_rd !== 4'b0) begin errors++; $display("FAIL bp_nopop cyc %0d got %b exp 0000", k, req_fifo_rd); end
         tick();
      end
      axi_axready = 1'b1;
      #1;
      checks++; if (transfifo_wr !== 1'b1 || transfifo_wrdata !== e0) begin errors++; $display("FAIL bp_hs got twr %0b data %h exp 1 %h", transfifo_wr, transfifo_wrdata, e0); end
      tick();
      checks++; if (outstanding_cnt !== 8'd1) begin errors++; $display("FAIL bp_cnt got %0d exp 1", outstanding_cnt); end
      checks++; if (req_fifo_rd !== 4'b0010) begin errors++; $display("FAIL bp_next_pop got %b exp 0010", req_fifo_rd); end
      tick();
      checks++; if (axi_addr !== 64'hCAFE_0040) begin errors++; $display("FAIL bp_next_addr got %h exp cafe0040", axi_addr); end
   endtask

   task automatic test_round_robin();
      int g, j;
      logic [63:0] ea;
      do_reset();
      for (int i = 0; i < NR; i++)
         for (int jj = 0; jj < 2; jj++)
            push(i, mk(64'h1000_0000 * (i + 1) + 64'(jj * 64), 6'(i * 4 + jj), 8'(jj), 3'(i), 16'(i * 16 + jj)));
      axi_axready = 1'b1;
      refresh();
      #1;
      for (int b = 0; b < 8; b++) begin
         g = b % 4;
         j = b / 4;
         ea = 64'h1000_0000 * (g + 1) + 64'(j * 64);
         checks++; if (req_fifo_rd !== 4'(1 << g)) begin errors++; $display("FAIL rr_pop beat %0d got %b exp %b", b, req_fifo_rd, 4'(1 << g)); end
         tick();
         checks++; if (axi_axvalid !== 1'b1 || req_fifo_rd !== 4'b0) begin errors++; $display("FAIL rr_issue beat %0d got valid %0b rd %b exp 1 0000", b, axi_axvalid, req_fifo_rd); end
         checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL rr_gid beat %0d got %0d exp %0d", b, grant_id, g); end
         checks++; if (axi_addr !== ea) begin errors++; $display("FAIL rr_addr beat %0d got %h exp %h", b, axi_addr, ea); end
         rsp_done = 1'b1;
         tick();
         rsp_done = 1'b0;
      end
      #1;
      checks++; if (outstanding_cnt !== 8'd0 || err_underflow !== 1'b0) begin errors++; $display("FAIL rr_cnt got cnt %0d err %0b exp 0 0", outstanding_cnt, err_underflow); end
      checks++; if (req_fifo_rd !== 4'b0) begin errors++; $display("FAIL rr_drained got %b exp 0000", req_fifo_rd); end
   endtask

   task automatic test_limit();
      do_reset();
      for (int k = 0; k < 3; k++) push(0, mk(64'h2000 + 64'(k * 16), 6'(k), 8'd0, 3'd0, 16'(k)));
      axi_axready = 1'b1;
      refresh();
      #1;
      checks++; if (req_fifo_rd !== 4'b0001) begin errors++; $display("FAIL lim_pop1 got %b exp 0001", req_fifo_rd); end
      tick(); tick();
      checks++; if (outstanding_cnt !== 8'd1 || req_fifo_rd !== 4'b0001) begin errors++; $display("FAIL lim_pop2 got cnt %0d rd %b exp 1 0001", outstanding_cnt, req_fifo_rd); end
      tick(); tick();
      checks++; if (outstanding_cnt !== 8'd2 || req_fifo_rd !== 4'b0) begin errors++; $display("FAIL lim_full got cnt %0d rd %b exp 2 0000", outstanding_cnt, req_fifo_rd); end
      tick();
      checks++; if (req_fifo_rd !== 4'b0 || axi_axvalid !== 1'b0) begin errors++; $display("FAIL lim_stall got rd %b valid %0b exp 0000 0", req_fifo_rd, axi_axvalid); end
      tick();
      checks++; if (req_fifo_rd !== 4'b0 || outstanding_cnt !== 8'd2) begin errors++; $display("FAIL lim_stall2 got rd %b cnt %0d exp 0000 2", req_fifo_rd, outstanding_cnt); end
      rsp_done = 1'b1;
      tick();
      rsp_done = 1'b0;
      #1;
      checks++; if (outstanding_cnt !== 8'd1 || req_fifo_rd !== 4'b0) begin errors++; $display("FAIL lim_drop got cnt %0d rd %b exp 1 0000", outstanding_cnt, req_fifo_rd); end
      tick();
      checks++; if (req_fifo_rd !== 4'b0001) begin errors++; $display("FAIL lim_resume got %b exp 0001", req_fifo_rd); end
      tick();
      checks++; if (axi_axvalid !== 1'b1 || axi_addr !== 64'h2020) begin errors++; $display("FAIL lim_third got valid %0b addr %h exp 1 2020", axi_axvalid, axi_addr); end
      tick();
      checks++; if (outstanding_cnt !== 8'd2) begin errors++; $display("FAIL lim_cnt_end got %0d exp 2", outstanding_cnt); end
   endtask

   task automatic test_simul_underflow();
      do_reset();
      push(3, mk(64'h3000, 6'd1, 8'd0, 3'd0, 16'd0));
      push(3, mk(64'h3040, 6'd2, 8'd0, 3'd0, 16'd1));
      axi_axready = 1'b1;
      refresh();
      tick(); tick();
      checks++; if (outstanding_cnt !== 8'd1) begin errors++; $display("FAIL sim_pre got %0d exp 1", outstanding_cnt); end
      tick();
      checks++; if (axi_axvalid !== 1'b1) begin errors++; $display("FAIL sim_valid got %0b exp 1", axi_axvalid); end
      rsp_done = 1'b1;
      tick();
      checks++; if (outstanding_cnt !== 8'd1) begin errors++; $display("FAIL sim_both got %0d exp 1", outstanding_cnt); end
      tick();
      checks++; if (outstanding_cnt !== 8'd0 || err_underflow !== 1'b0) begin errors++; $display("FAIL sim_dec got cnt %0d err %0b exp 0 0", outstanding_cnt, err_underflow); end
      tick();
      checks++; if (outstanding_cnt !== 8'd0 || err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got cnt %0d err %0b exp 0 1", outstanding_cnt, err_underflow); end
      rsp_done = 1'b0;
      tick(); tick();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %0b exp 1", err_underflow); end
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      push(0, mk(64'hA000, 6'd1, 8'd0, 3'd0, 16'd0));
      push(0, mk(64'hA100, 6'd2, 8'd0, 3'd0, 16'd1));
      push(3, mk(64'hC000, 6'd3, 8'd0, 3'd0, 16'd2));
      push(3, mk(64'hC100, 6'd4, 8'd0, 3'd0, 16'd3));
      axi_axready = 1'b1;
      refresh();
      #1;
      checks++; if (req_fifo_rd !== 4'b0001) begin errors++; $display("FAIL rmi_pop0 got %b exp 0001", req_fifo_rd); end
      tick(); tick();
      checks++; if (req_fifo_rd !== 4'b1000) begin errors++; $display("FAIL rmi_pop3 got %b exp 1000", req_fifo_rd); end
      axi_axready = 1'b0;
      tick();
      checks++; if (axi_axvalid !== 1'b1 || axi_addr !== 64'hC000) begin errors++; $display("FAIL rmi_issue got valid %0b addr %h exp 1 c000", axi_axvalid, axi_addr); end
      reset = 1'b1;
      #1;
      checks++; if (axi_axvalid !== 1'b0 || transfifo_wr !== 1'b0) begin errors++; $display("FAIL rmi_async got valid %0b twr %0b exp 0 0", axi_axvalid, transfifo_wr); end
      checks++; if (axi_addr !== 64'd0) begin errors++; $display("FAIL rmi_discard got %h exp 0", axi_addr); end
      tick();
      reset = 1'b0;
      axi_axready = 1'b1;
      #1;
      checks++; if (req_fifo_rd !== 4'b0001) begin errors++; $display("FAIL rmi_restart got %b exp 0001", req_fifo_rd); end
      tick();
      checks++; if (axi_axvalid !== 1'b1 || grant_id !== 2'd0 || axi_addr !== 64'hA100) begin errors++; $display("FAIL rmi_reissue got valid %0b gid %0d addr %h exp 1 0 a100", axi_axvalid, grant_id, axi_addr); end
      tick();
      checks++; if (outstanding_cnt !== 8'd1 || req_fifo_rd !== 4'b1000) begin errors++; $display("FAIL rmi_cnt got cnt %0d rd %b exp 1 1000", outstanding_cnt, req_fifo_rd); end
      tick();
      checks++; if (axi_addr !== 64'hC100) begin errors++; $display("FAIL rmi_next got %h exp c100", axi_addr); end
   endtask

   initial begin
      reset = 1'b1;
      axi_axready = 1'b0;
      rsp_done = 1'b0;
      req_fifo_empty = '1;
      req_fifo_rddata = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_limit();
      test_simul_underflow();
      test_reset_mid_issue();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
